// File: rtl/mul_sched_pkg.sv
// Shared constants for the multiply scheduler slice.
// The default entry count, select width and speculative-tag width are defined
// here so that every block using the multiply reservation station agrees on them.
package mul_sched_pkg;

  // Default number of multiply reservation-station entries
  localparam int MUL_ENT_NUM = 2;
  // Width of an entry index for the default entry count
  localparam int MUL_ENT_SEL = 1;
  // One-hot speculative tag width
  localparam int SPECTAG_LEN = 5;
  // Default multiplier pipeline depth
  localparam int MUL_LAT_DEF = 3;

endpackage

// File: rtl/mul_sched_prio.sv
// prio_enc: find-first-set (lowest index wins) with a valid flag.
// Used for free-entry allocation and for issue selection.
module prio_enc
  import mul_sched_pkg::*;
#(
  parameter int W = 2,
  localparam int OW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  in_vec,
  output logic [OW-1:0] enc,
  output logic          valid
);

  // Scan from the top down so the lowest set bit is the one that sticks
  always_comb begin
    enc   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        enc   = OW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: allocation, issue selection and result pipeline for the multiply
// reservation station.
//
// Build option: define MUL_SCHED_RR_EN to select round-robin issue starting at
// a pointer that moves past each issued entry; without it issue is fixed
// priority (lowest index) and no pointer register exists.
//
// Handshake: the final pipeline stage presents mul_valid/mul_spectag and holds
// them stable until wb_ack is seen in a cycle where mul_valid is high; stalls
// ripple upstream one stage at a time, and issue (clearbusy) only happens when
// stage 0 can take the op at the next edge.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int ENT_NUM     = mul_sched_pkg::MUL_ENT_NUM,
  parameter int MUL_LAT     = mul_sched_pkg::MUL_LAT_DEF,
  parameter int SPECTAG_LEN = mul_sched_pkg::SPECTAG_LEN,
  localparam int SEL_W      = $clog2(ENT_NUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ENT_NUM-1:0]     busyvec,
  input  logic [ENT_NUM-1:0]     ready,
  input  logic [1:0]             req_num,
  output logic                   alloc_ok,
  output logic [SEL_W-1:0]       allocent1,
  output logic [SEL_W-1:0]       allocent2,
  output logic                   clearbusy,
  output logic [SEL_W-1:0]       issueaddr,
  input  logic [SPECTAG_LEN-1:0] issue_spectag,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  output logic                   mul_valid,
  output logic [SPECTAG_LEN-1:0] mul_spectag,
  input  logic                   wb_ack
);

  localparam int LAST = MUL_LAT - 1;

  // ---------------------------------------------------------------------------
  // Allocation: first and second free entries
  // ---------------------------------------------------------------------------
  logic [ENT_NUM-1:0] free_vec;
  logic [ENT_NUM-1:0] free2_vec;
  logic               ent1_v;
  logic               ent2_v;
  logic [1:0]         free_cnt;

  assign free_vec  = ~busyvec;
  // Hide the first pick so the second encoder finds the next free entry
  assign free2_vec = free_vec & ~(ENT_NUM'(1) << allocent1);

  prio_enc #(.W(ENT_NUM)) u_alloc1 (
    .in_vec (free_vec),
    .enc    (allocent1),
    .valid  (ent1_v)
  );

  prio_enc #(.W(ENT_NUM)) u_alloc2 (
    .in_vec (free2_vec),
    .enc    (allocent2),
    .valid  (ent2_v)
  );

  // Free count saturates at two, which is all req_num can ask for
  assign free_cnt = 2'(ent1_v) + 2'(ent2_v);
  assign alloc_ok = (free_cnt >= req_num);

  // ---------------------------------------------------------------------------
  // Issue selection
  // ---------------------------------------------------------------------------
  logic [ENT_NUM-1:0] cand_vec;
  logic [SEL_W-1:0]   sel_addr;
  logic               sel_v;
  logic               accept;

  assign cand_vec = ready & busyvec;

`ifdef MUL_SCHED_RR_EN
  logic [SEL_W-1:0]   rr_ptr;
  logic [ENT_NUM-1:0] ge_mask;
  logic [ENT_NUM-1:0] hi_vec;
  logic [SEL_W-1:0]   hi_addr;
  logic               hi_v;
  logic [SEL_W-1:0]   lo_addr;
  logic               lo_v;

  // Entries at or above the pointer get first chance
  always_comb begin
    ge_mask = '0;
    for (int j = 0; j < ENT_NUM; j++) begin
      ge_mask[j] = (SEL_W'(j) >= rr_ptr);
    end
  end

  assign hi_vec = cand_vec & ge_mask;

  prio_enc #(.W(ENT_NUM)) u_sel_hi (
    .in_vec (hi_vec),
    .enc    (hi_addr),
    .valid  (hi_v)
  );

  prio_enc #(.W(ENT_NUM)) u_sel_lo (
    .in_vec (cand_vec),
    .enc    (lo_addr),
    .valid  (lo_v)
  );

  // Wrap to the lowest candidate when nothing sits at or above the pointer
  assign sel_addr = hi_v ? hi_addr : lo_addr;
  assign sel_v    = lo_v;

  // Pointer moves to the entry after the one just issued
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (clearbusy) begin
      rr_ptr <= (issueaddr == SEL_W'(ENT_NUM - 1)) ? '0 : issueaddr + SEL_W'(1);
    end
  end
`else
  prio_enc #(.W(ENT_NUM)) u_sel (
    .in_vec (cand_vec),
    .enc    (sel_addr),
    .valid  (sel_v)
  );
`endif

  assign issueaddr = sel_addr;
  // A mispredict cycle never issues: the op's tag could belong to the killed path
  assign clearbusy = !reset && sel_v && accept && !prmiss;

  // ---------------------------------------------------------------------------
  // Result pipeline
  // ---------------------------------------------------------------------------
  logic [MUL_LAT-1:0]     stg_valid;
  logic [SPECTAG_LEN-1:0] stg_tag [MUL_LAT];
  logic [MUL_LAT-1:0]     stg_adv;
  logic [MUL_LAT-1:0]     nxt_valid;
  logic [SPECTAG_LEN-1:0] nxt_tag [MUL_LAT];

  // A stage moves when it or any stage below it has a hole, or writeback acks
  always_comb begin : adv_chain
    logic run;
    run           = wb_ack || !stg_valid[LAST];
    stg_adv       = '0;
    stg_adv[LAST] = run;
    for (int i = MUL_LAT - 2; i >= 0; i--) begin
      run        = run || !stg_valid[i];
      stg_adv[i] = run;
    end
  end

  assign accept = stg_adv[0];

  // Shift the pipe, then apply kill (mispredict) or tag clear (confirm)
  always_comb begin : next_state
    logic [MUL_LAT-1:0]     mv_valid;
    logic [SPECTAG_LEN-1:0] mv_tag [MUL_LAT];
    mv_valid    = '0;
    mv_tag      = '{default: '0};
    mv_valid[0] = stg_adv[0] ? clearbusy : stg_valid[0];
    mv_tag[0]   = stg_adv[0] ? issue_spectag : stg_tag[0];
    for (int i = 1; i < MUL_LAT; i++) begin
      mv_valid[i] = stg_adv[i] ? stg_valid[i-1] : stg_valid[i];
      mv_tag[i]   = stg_adv[i] ? stg_tag[i-1] : stg_tag[i];
    end
    nxt_valid = mv_valid;
    nxt_tag   = mv_tag;
    for (int i = 0; i < MUL_LAT; i++) begin
      if (prmiss) begin
        if ((mv_tag[i] & specfixtag) != '0) begin
          nxt_valid[i] = 1'b0;
        end
      end else if (prsuccess) begin
        nxt_tag[i] = mv_tag[i] & ~prtag;
      end
    end
  end

  // Stage registers; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        stg_tag[i] <= '0;
      end
    end else begin
      stg_valid <= nxt_valid;
      for (int i = 0; i < MUL_LAT; i++) begin
        stg_tag[i] <= nxt_tag[i];
      end
    end
  end

  assign mul_valid   = stg_valid[LAST];
  assign mul_spectag = stg_tag[LAST];

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 SHALL have parameter ENT_NUM, default 2: number of multiply reservation-station entries, range 2..8.
REQ-002 SHALL have parameter MUL_LAT, default 3: multiplier pipeline depth in cycles, range 1..4.
REQ-003 SHALL have parameter SPECTAG_LEN, default 5: speculative-tag width (one-hot).
REQ-004 SHALL have port `clk`, input, 1 bit: clock.
REQ-005 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port `busyvec`, input, ENT_NUM bits: entry occupied.
REQ-007 SHALL have port `ready`, input, ENT_NUM bits: entry operands resolved.
REQ-008 SHALL have port `req_num`, input, 2 bits: allocations requested this cycle (0..2).
REQ-009 SHALL have port `alloc_ok`, output, 1 bit: enough free entries for `req_num`.
REQ-010 SHALL have ports `allocent1` and `allocent2`, output, clog2(ENT_NUM) bits each: first and second free entry.
REQ-011 SHALL have port `clearbusy`, output, 1 bit: an issue occurs this cycle.
REQ-012 SHALL have port `issueaddr`, output, clog2(ENT_NUM) bits: entry issued.
REQ-013 SHALL have port `issue_spectag`, input, SPECTAG_LEN bits: spectag of the entry at `issueaddr`.
REQ-014 SHALL have ports `prmiss` and `prsuccess`, input, 1 bit each: branch mispredict / confirm.
REQ-015 SHALL have ports `prtag` and `specfixtag`, input, SPECTAG_LEN bits each: resolved tag / kill mask.
REQ-016 SHALL have port `mul_valid`, output, 1 bit: result at the final stage is valid.
REQ-017 SHALL have port `mul_spectag`, output, SPECTAG_LEN bits: tag of the final-stage result.
REQ-018 SHALL have port `wb_ack`, input, 1 bit: writeback accepts the final-stage result.

Function
REQ-019 SHALL drive `allocent1` with the lowest-index entry whose `busyvec` bit is 0, and `allocent2` with the next lowest; `alloc_ok` = (free count >= `req_num`).
REQ-020 SHALL pick an issue candidate from ready&busyvec only when pipeline stage 0 can accept; `clearbusy` = candidate exists & accept & !`prmiss`.
REQ-021 SHALL make `clearbusy`/`issueaddr` combinational in the same cycle, with the op entering stage 0 at the next edge (latency MUL_LAT cycles to `mul_valid`).
REQ-022 SHALL keep a valid bit and spectag per pipeline stage; a stage advances when the downstream stage is empty or advancing.
REQ-023 SHALL make the final stage advance on `wb_ack` or when empty; `mul_valid` holds with a stable spectag until acked (stall backpressure propagates upstream).
REQ-024 SHALL clear every stage valid with (spectag & `specfixtag`) != 0 on `prmiss`, including a stalled final stage; an ack in the same cycle is ignored for killed ops.
REQ-025 SHALL clear bits equal to `prtag` in every stage spectag on `prsuccess`.
REQ-026 SHALL apply `prmiss` in preference to `prsuccess` when both are asserted.
REQ-027 SHALL issue only one op per cycle; an empty ready set or a full stalled pipe gives `clearbusy` = 0.

Reset
REQ-028 SHALL on reset clear all stage valids and spectags to 0, the RR pointer to 0, `mul_valid` to 0 and `clearbusy` to 0; reset mid-stall discards in-flight ops.

Configuration
REQ-029 SHALL, with MUL_SCHED_RR_EN defined, select round-robin starting at the pointer, which moves to issueaddr+1 (mod ENT_NUM) on each issue.
REQ-030 SHALL, without MUL_SCHED_RR_EN, use fixed priority (lowest index) and have no pointer register.

Structure
REQ-031 SHALL take the MUL_ENT_NUM/MUL_ENT_SEL/SPECTAG_LEN defaults from the shared constants include.
REQ-032 SHALL implement the find-first-set used for allocation and selection in a single sub-module, `prio_enc` (parameterised width, valid output), instantiated several times.

Verification
REQ-033 SHALL verify: reset, busyvec=2'b00, req_num=2 -> allocent1=0, allocent2=1, alloc_ok=1; busyvec=2'b01, req_num=2 -> alloc_ok=0.
REQ-034 SHALL verify: ready=busy=2'b10 at cycle 0, MUL_LAT=3 -> clearbusy=1, issueaddr=1 at cycle 0; mul_valid=1 at cycle 3.
REQ-035 SHALL verify: wb_ack held 0 for 4 cycles with 3 ops issued -> pipe fills, clearbusy=0 while full, mul_spectag stable; ack releases one op per cycle.
REQ-036 SHALL verify: in-flight tags 5'b00010 and 5'b00100, prmiss with specfixtag=5'b00110 -> both killed, mul_valid never rises.
REQ-037 SHALL verify: RR_EN, both entries ready for 4 cycles -> issueaddr 0,1,0,1; without RR_EN -> issueaddr 0 every cycle.
